tick_scheduler: RTL and testbench

//  Runtime-programmable multi-channel time base. A shared prescaler divides clk_in into a base tick.

---
 rtl/tick_scheduler.sv | 161 ++++++++++++++++
 tb/tb_tick_scheduler.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/tick_scheduler.sv
// tick_scheduler: shared prescaler feeding N_CH runtime-programmable tick / square-wave channels.
// Define TICK_SCHED_SYNC_EN to add the sync_start phase-alignment input.
module tick_scheduler #(
    parameter  int N_CH     = 4,
    parameter  int PRESCALE = 100,
    parameter  int PERIOD_W = 16,
    localparam int CH_W     = (N_CH > 1) ? $clog2(N_CH) : 1,
    localparam int PRE_W    = (PRESCALE > 1) ? $clog2(PRESCALE) : 1
) (
    input  logic                clk_in,
    input  logic                reset,
`ifdef TICK_SCHED_SYNC_EN
    input  logic                sync_start,
`endif
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic [CH_W-1:0]     cfg_ch,
    input  logic [PERIOD_W-1:0] cfg_period,
    output logic [N_CH-1:0]     tick,
    output logic [N_CH-1:0]     clk_out,
    output logic [N_CH-1:0]     active
);

    typedef enum logic {S_OFF = 1'b0, S_RUN = 1'b1} ch_state_t;

    logic [PRE_W-1:0]    r_pre_cnt;
    logic                w_base_tick;
    logic                w_sync;

    ch_state_t           r_state     [N_CH];
    ch_state_t           w_state_nx  [N_CH];
    logic [PERIOD_W-1:0] r_period    [N_CH];
    logic [PERIOD_W-1:0] w_period_nx [N_CH];
    logic [PERIOD_W-1:0] r_cnt       [N_CH];
    logic [PERIOD_W-1:0] w_cnt_nx    [N_CH];
    logic [PERIOD_W-1:0] r_shadow    [N_CH];
    logic [PERIOD_W-1:0] w_shadow_nx [N_CH];
    logic [N_CH-1:0]     r_pend, w_pend_nx;
    logic [N_CH-1:0]     r_tick, w_tick_nx;
    logic [N_CH-1:0]     r_clk,  w_clk_nx;
    logic [N_CH-1:0]     w_sel;
    logic [N_CH-1:0]     w_term;

`ifdef TICK_SCHED_SYNC_EN
    assign w_sync = sync_start;
`else
    assign w_sync = 1'b0;
`endif

    assign w_base_tick = (r_pre_cnt == PRE_W'(PRESCALE - 1));

    always_ff @(posedge clk_in) begin
        if (reset) begin
            r_pre_cnt <= '0;
        end else if (w_base_tick || w_sync) begin
            r_pre_cnt <= '0;
        end else begin
            r_pre_cnt <= r_pre_cnt + PRE_W'(1);
        end
    end

    // Out-of-range cfg_ch matches no channel: reads ready, transfer dropped.
    always_comb begin
        cfg_ready = 1'b1;
        w_sel     = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (cfg_ch == CH_W'(i)) begin
                cfg_ready = ~r_pend[i];
                w_sel[i]  = cfg_valid & ~r_pend[i];
            end
        end
    end

    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_term[i] = w_base_tick && (r_cnt[i] == r_period[i] - PERIOD_W'(1));
            active[i] = (r_state[i] == S_RUN);
        end
    end

    // An accepted channel always had pend=0, so a shadow-driven switch to OFF never meets an accept.
    always_comb begin
        for (int unsigned i = 0; i < N_CH; i++) begin
            w_state_nx[i]  = r_state[i];
            w_period_nx[i] = r_period[i];
            w_cnt_nx[i]    = r_cnt[i];
            w_shadow_nx[i] = r_shadow[i];
            w_pend_nx[i]   = r_pend[i];
            w_clk_nx[i]    = r_clk[i];
            w_tick_nx[i]   = 1'b0;
            case (r_state[i])
                S_OFF: begin
                    if (w_sel[i] && (cfg_period != '0)) begin
                        w_state_nx[i]  = S_RUN;
                        w_period_nx[i] = cfg_period;
                        w_cnt_nx[i]    = '0;
                        w_clk_nx[i]    = 1'b0;
                    end
                end
                S_RUN: begin
                    if (w_sync) begin
                        w_cnt_nx[i] = '0;
                        w_clk_nx[i] = 1'b0;
                        if (r_pend[i]) begin
                            w_period_nx[i] = r_shadow[i];
                            w_pend_nx[i]   = 1'b0;
                            if (r_shadow[i] == '0) w_state_nx[i] = S_OFF;
                        end
                    end else if (w_term[i]) begin
                        w_tick_nx[i] = 1'b1;
                        w_clk_nx[i]  = ~r_clk[i];
                        w_cnt_nx[i]  = '0;
                        if (r_pend[i]) begin
                            w_period_nx[i] = r_shadow[i];
                            w_pend_nx[i]   = 1'b0;
                            if (r_shadow[i] == '0) begin
                                w_state_nx[i] = S_OFF;
                                w_clk_nx[i]   = 1'b0;
                            end
                        end
                    end else if (w_base_tick) begin
                        w_cnt_nx[i] = r_cnt[i] + PERIOD_W'(1);
                    end
                    if (w_sel[i]) begin
                        w_shadow_nx[i] = cfg_period;
                        w_pend_nx[i]   = 1'b1;
                    end
                end
                default: w_state_nx[i] = S_OFF;
            endcase
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_state[i]  <= S_OFF;
                r_period[i] <= '0;
                r_cnt[i]    <= '0;
                r_shadow[i] <= '0;
            end
            r_pend <= '0;
            r_tick <= '0;
            r_clk  <= '0;
        end else begin
            for (int unsigned i = 0; i < N_CH; i++) begin
                r_state[i]  <= w_state_nx[i];
                r_period[i] <= w_period_nx[i];
                r_cnt[i]    <= w_cnt_nx[i];
                r_shadow[i] <= w_shadow_nx[i];
            end
            r_pend <= w_pend_nx;
            r_tick <= w_tick_nx;
            r_clk  <= w_clk_nx;
        end
    end

    assign tick    = r_tick;
    assign clk_out = r_clk;

endmodule

// File: tb/tb_tick_scheduler.sv
// tb_tick_scheduler: scoreboard bench for tick_scheduler with N_CH=4, PRESCALE=4, PERIOD_W=8.
`timescale 1ns/1ps
module tb_tick_scheduler;
    localparam int NC = 4;
    localparam int PS = 4;
    localparam int PW = 8;

    logic          clk_in     = 1'b0;
    logic          reset      = 1'b1;
    logic          cfg_valid  = 1'b0;
    logic [1:0]    cfg_ch     = '0;
    logic [PW-1:0] cfg_period = '0;
    logic          cfg_ready;
    logic [NC-1:0] tick, clk_out, active;
`ifdef TICK_SCHED_SYNC_EN
    logic          sync_start = 1'b0;
`endif

    tick_scheduler #(.N_CH(NC), .PRESCALE(PS), .PERIOD_W(PW)) dut (
        .clk_in     (clk_in),
        .reset      (reset),
`ifdef TICK_SCHED_SYNC_EN
        .sync_start (sync_start),
`endif
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_ch     (cfg_ch),
        .cfg_period (cfg_period),
        .tick       (tick),
        .clk_out    (clk_out),
        .active     (active)
    );

    always #5 clk_in = ~clk_in;

    int n_cmp = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Behavioural reference: one update per clock edge, expected outputs queued for the monitor.
    int          m_pre;
    bit          m_run [NC];
    int          m_p   [NC];
    int          m_cnt [NC];
    int          m_sh  [NC];
    bit          m_pend[NC];
    bit          m_tick[NC];
    bit          m_clk [NC];
    bit          m_bt, m_acc, m_syn;
    int          m_sel;
    logic [11:0] m_vec;
    logic [11:0] exp_q[$];
    int          cyc_no = 0;

    initial for (int c = 0; c < NC; c++) m_pend[c] = 1'b0;

    always @(posedge clk_in) begin
        cyc_no++;
        m_syn = 1'b0;
`ifdef TICK_SCHED_SYNC_EN
        m_syn = sync_start;
`endif
        m_sel = int'(cfg_ch);
        m_acc = cfg_valid && !m_pend[m_sel];
        if (reset) begin
            m_pre = 0;
            for (int c = 0; c < NC; c++) begin
                m_run[c] = 0; m_p[c] = 0; m_cnt[c] = 0; m_sh[c] = 0;
                m_pend[c] = 0; m_tick[c] = 0; m_clk[c] = 0;
            end
        end else begin
            m_bt  = (m_pre == PS - 1);
            m_pre = (m_bt || m_syn) ? 0 : m_pre + 1;
            for (int c = 0; c < NC; c++) begin
                m_tick[c] = 0;
                if (m_run[c] && m_syn) begin
                    m_cnt[c] = 0;
                    m_clk[c] = 0;
                    if (m_pend[c]) begin
                        m_p[c] = m_sh[c]; m_pend[c] = 0;
                        if (m_p[c] == 0) m_run[c] = 0;
                    end
                end else if (m_run[c] && m_bt) begin
                    if (m_cnt[c] == m_p[c] - 1) begin
                        m_tick[c] = 1;
                        m_clk[c]  = !m_clk[c];
                        m_cnt[c]  = 0;
                        if (m_pend[c]) begin
                            m_p[c] = m_sh[c]; m_pend[c] = 0;
                            if (m_p[c] == 0) begin m_run[c] = 0; m_clk[c] = 0; end
                        end
                    end else begin
                        m_cnt[c]++;
                    end
                end
                if (m_acc && m_sel == c) begin
                    if (!m_run[c]) begin
                        if (cfg_period != 0) begin
                            m_run[c] = 1; m_p[c] = int'(cfg_period); m_cnt[c] = 0; m_clk[c] = 0;
                        end
                    end else begin
                        m_sh[c] = int'(cfg_period); m_pend[c] = 1;
                    end
                end
            end
        end
        for (int c = 0; c < NC; c++) begin
            m_vec[8 + c] = m_tick[c];
            m_vec[4 + c] = m_clk[c];
            m_vec[c]     = m_run[c];
        end
        exp_q.push_back(m_vec);
    end

    // Monitor: compare queued expectations and collect tick statistics.
    int          tick_cnt[NC];
    int          last_t  [NC];
    int          prev_t  [NC];
    int          coinc = 0;
    logic [11:0] mon_e;

    initial for (int c = 0; c < NC; c++) begin tick_cnt[c] = 0; last_t[c] = 0; prev_t[c] = 0; end

    always @(negedge clk_in) begin
        if (exp_q.size() > 0) begin
            mon_e = exp_q.pop_front();
            chk("outputs", {20'd0, tick, clk_out, active}, {20'd0, mon_e});
        end
        chk("cfg_ready", {31'd0, cfg_ready}, {31'd0, !m_pend[int'(cfg_ch)]});
        for (int c = 0; c < NC; c++) begin
            if (tick[c] === 1'b1) begin
                tick_cnt[c]++;
                prev_t[c] = last_t[c];
                last_t[c] = cyc_no;
            end
        end
        if (tick[0] === 1'b1 && tick[2] === 1'b1) coinc++;
    end

    task automatic step(input int n);
        repeat (n) @(negedge clk_in);
        #1;
    endtask

    task automatic send(input int ch, input int p);
        int w = 0;
        cfg_ch     = 2'(ch);
        cfg_period = PW'(p);
        #1;
        while (!cfg_ready && w < 200) begin
            step(1);
            w++;
        end
        if (!cfg_ready) chk("cfg_ready_wait", {31'd0, cfg_ready}, 32'd1);
        cfg_valid = 1'b1;
        step(1);
        cfg_valid = 1'b0;
    endtask

    int n0, n1, tot;

    initial begin
        step(3);
        chk("rst_tick",    {28'd0, tick},    32'd0);
        chk("rst_clk_out", {28'd0, clk_out}, 32'd0);
        chk("rst_active",  {28'd0, active},  32'd0);
        chk("rst_ready",   {31'd0, cfg_ready}, 32'd1);
        reset = 1'b0;
        step(10);

        send(0, 3);
        chk("ch0_active", {31'd0, active[0]}, 32'd1);
        step(60);
        chk("ch0_spacing_p3", 32'(last_t[0] - prev_t[0]), 32'd12);

        send(0, 5);
        cfg_ch = 2'd0; #1;
        chk("ch0_ready_pend", {31'd0, cfg_ready}, 32'd0);
        cfg_ch = 2'd1; #1;
        chk("ch1_ready_free", {31'd0, cfg_ready}, 32'd1);
        cfg_ch = 2'd0;
        n0 = tick_cnt[0];
        for (int w = 0; w < 40 && tick_cnt[0] == n0; w++) step(1);
        chk("ch0_ready_after_tick", {31'd0, cfg_ready}, 32'd1);
        step(70);
        chk("ch0_spacing_p5", 32'(last_t[0] - prev_t[0]), 32'd20);

        send(3, 1);
        send(2, 0);
        chk("ch2_off_noop", {31'd0, active[2]}, 32'd0);
        step(20);
        chk("ch3_spacing_p1", 32'(last_t[3] - prev_t[3]), 32'd4);

        send(1, 2);
        step(30);
        chk("ch1_spacing_p2", 32'(last_t[1] - prev_t[1]), 32'd8);
        send(1, 0);
        n1 = tick_cnt[1];
        step(30);
        chk("ch1_final_tick",   32'(tick_cnt[1] - n1), 32'd1);
        chk("ch1_inactive",     {31'd0, active[1]},  32'd0);
        chk("ch1_clk_out_low",  {31'd0, clk_out[1]}, 32'd0);
        step(20);
        chk("ch1_no_more_ticks", 32'(tick_cnt[1] - n1), 32'd1);

        send(0, 7);
        chk("ch0_pend_before_rst", {31'd0, cfg_ready}, 32'd0);
        reset = 1'b1;
        step(1);
        reset = 1'b0;
        chk("midrst_tick",    {28'd0, tick},    32'd0);
        chk("midrst_clk_out", {28'd0, clk_out}, 32'd0);
        chk("midrst_active",  {28'd0, active},  32'd0);
        chk("midrst_ready",   {31'd0, cfg_ready}, 32'd1);
        tot = tick_cnt[0] + tick_cnt[1] + tick_cnt[2] + tick_cnt[3];
        step(50);
        chk("midrst_no_ticks", 32'(tick_cnt[0] + tick_cnt[1] + tick_cnt[2] + tick_cnt[3] - tot), 32'd0);
        chk("midrst_still_off", {28'd0, active}, 32'd0);

`ifdef TICK_SCHED_SYNC_EN
        send(0, 2);
        send(2, 4);
        step(37);
        sync_start = 1'b1;
        step(1);
        sync_start = 1'b0;
        chk("sync_clk_out", {28'd0, clk_out}, 32'd0);
        chk("sync_no_tick", {28'd0, tick},    32'd0);
        n0 = tick_cnt[2];
        n1 = coinc;
        step(80);
        chk("sync_ch2_ticks",   32'(tick_cnt[2] - n0), 32'd5);
        chk("sync_ch2_spacing", 32'(last_t[2] - prev_t[2]), 32'd16);
        chk("sync_coincident",  32'(coinc - n1), 32'd5);
`endif

        step(3);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
